// File: rtl/data_distributor.sv
// data_distributor: loads six words from a valid/ready stream into slots 0..5 in order
// Ports: CLK/RST (sync, active-high), dataIn/dataValid/dataReady stream input,
// clear restarts the fill, data0..5 slot registers, select0..5 one-cycle write strobes,
// loaded level once all six slots are written, loadDone one-cycle pulse on slot 5.
module data_distributor #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = 32'hfefefefe
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             dataValid,
  output logic             dataReady,
  input  logic             clear,
  output logic [WIDTH-1:0] data0,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] data3,
  output logic [WIDTH-1:0] data4,
  output logic [WIDTH-1:0] data5,
  output logic             select0,
  output logic             select1,
  output logic             select2,
  output logic             select3,
  output logic             select4,
  output logic             select5,
  output logic             loaded,
  output logic             loadDone
);
  typedef enum logic [1:0] {FILL = 2'd0, FULL = 2'd1} state_t;
  state_t           state;
  logic [2:0]       idx;
  logic [5:0]       sel;
  logic [WIDTH-1:0] d [6];
  assign dataReady = state == FILL && idx < 3'd6 && !RST && !clear;
  assign {data5, data4, data3, data2, data1, data0} = {d[5], d[4], d[3], d[2], d[1], d[0]};
  assign {select5, select4, select3, select2, select1, select0} = sel;
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 6; i++) d[i] <= RESET_VALUE;
      sel      <= '0;
      loaded   <= 1'b0;
      loadDone <= 1'b0;
      state    <= FILL;
      idx      <= '0;
    end else begin
      sel      <= '0;
      loadDone <= 1'b0;
      if (clear) begin
        state  <= FILL;
        idx    <= '0;
        loaded <= 1'b0;
      end else if (state == FILL && idx < 3'd6) begin
        if (dataValid) begin
          d[idx] <= dataIn;
          sel    <= 6'd1 << idx;
          if (idx == 3'd5) begin
            state    <= FULL;
            loaded   <= 1'b1;
            loadDone <= 1'b1;
          end else begin
            idx <= idx + 3'd1;
          end
        end
      end else if (state != FULL) begin
        // illegal state or index: restart the fill
        state  <= FILL;
        idx    <= '0;
        loaded <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_data_distributor.sv
// tb_data_distributor: directed plus random stimulus against a slot-count reference model
module tb_data_distributor;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        clear = 1'b0;
  logic        dataValid = 1'b0;
  logic [31:0] dataIn = '0;
  logic        dataReady, loaded, loadDone;
  logic [31:0] data0, data1, data2, data3, data4, data5;
  logic        select0, select1, select2, select3, select4, select5;
  int          cmp_n = 0;
  int          err_n = 0;
  logic [31:0] m [6];
  int          n = 0;
  logic [5:0]  esel = '0;
  logic        edone = 1'b0;
  logic [31:0] bw [6] = '{32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210, 32'h00000000, 32'hffffffff};
  logic [15:0] gap = 16'b1000011000011001;
  data_distributor dut (
    .CLK(CLK), .RST(RST), .dataIn(dataIn), .dataValid(dataValid), .dataReady(dataReady),
    .clear(clear), .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .data4(data4), .data5(data5), .select0(select0), .select1(select1), .select2(select2),
    .select3(select3), .select4(select4), .select5(select5), .loaded(loaded), .loadDone(loadDone)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    if (obs !== exp) begin
      err_n++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic check_out();
    logic [31:0] d [6];
    d[0] = data0; d[1] = data1; d[2] = data2; d[3] = data3; d[4] = data4; d[5] = data5;
    for (int i = 0; i < 6; i++) chk($sformatf("data%0d", i), d[i], m[i]);
    chk("select", {26'b0, select5, select4, select3, select2, select1, select0}, {26'b0, esel});
    chk("loaded", {31'b0, loaded}, {31'b0, n == 6});
    chk("loadDone", {31'b0, loadDone}, {31'b0, edone});
  endtask
  task automatic cyc(input logic r, input logic c, input logic v, input logic [31:0] w);
    RST = r; clear = c; dataValid = v; dataIn = w;
    #1;
    chk("dataReady", {31'b0, dataReady}, {31'b0, !r && !c && n < 6});
    esel = '0;
    edone = 1'b0;
    if (r) begin
      for (int i = 0; i < 6; i++) m[i] = 32'hfefefefe;
      n = 0;
    end else if (c) begin
      n = 0;
    end else if (v && n < 6) begin
      m[n] = w;
      esel[n] = 1'b1;
      n++;
      edone = n == 6;
    end
    @(posedge CLK);
    @(negedge CLK);
    check_out();
  endtask
  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 32'h5555aaaa);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, bw[i]);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 32'hdeadbeef);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, gap[i], gap[i] ? bw[n] : 32'hbad0bad0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h10 + i);
    cyc(0, 1, 1, 32'haaaaaaaa);
    cyc(0, 0, 1, 32'h11111111);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'h20 + i);
    cyc(0, 1, 1, 32'h99999999);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'h30 + i);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 32'h44444444);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(39) == 0, $urandom_range(19) == 0, $urandom_range(1) == 1, $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule

// File: doc/data_distributor.md
Name: data_distributor

Overview:
- Write-side counterpart of the one-hot six-way result selector.
- Accepts a stream of 32-bit words over a valid/ready handshake.
- Fills six output word registers in fixed order 0..5 and emits a one-cycle one-hot strobe per slot written.
- Loads the six per-run configuration words (e.g. target digest words plus range words) into the MD5 core array. Flags completion when all six are loaded.

Parameters:
- WIDTH, 32, data word width.
- RESET_VALUE, 32'hfefefefe, value of every dataN output after RST (same filler pattern the selector emits on invalid select).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- dataIn  input  WIDTH  incoming word.
- dataValid  input  1  dataIn holds a valid word.
- dataReady  output  1  block can accept a word this cycle.
- clear  input  1  synchronous restart of the fill sequence.
- data0..data5  output  WIDTH each  registered slot contents.
- select0..select5  output  1 each  one-cycle strobe: slot N written this cycle.
- loaded  output  1  level; all six slots written since last RST/clear.
- loadDone  output  1  one-cycle pulse when slot 5 is written.

Behaviour:
- Reset values, applied at any rising edge with RST=1 (RST has priority over everything):
  - data0..data5 = RESET_VALUE.
  - select0..select5 = 0.
  - loaded = 0, loadDone = 0.
  - State = FILL, slot index = 0.
- dataReady = (state==FILL) && !RST && !clear. It is combinational from the state register and inputs.
- Accept condition: dataValid && dataReady, sampled at the rising edge.
- States:
  - FILL (slot index 0..5).
  - FULL.
- FILL, on accept with index N:
  - dataN <= dataIn; the other slots hold.
  - selectN <= 1 for exactly the next cycle; the other selects are 0.
  - If N<5: index <= N+1, stay in FILL.
  - If N==5: state <= FULL, loaded <= 1, loadDone <= 1 for one cycle. These appear in the same cycle as select5.
- FILL, no accept: index holds, all selects 0.
- FULL:
  - dataReady=0. dataValid is ignored and words are not consumed.
  - Outputs hold; loaded stays 1; loadDone is 0 after its single pulse.
- Latency: a word accepted at edge k appears on dataN, with its selectN high, during cycle k..k+1 (one register stage). No combinational path from dataIn to dataN.
- Select outputs are mutually exclusive: at most one is high in any cycle, and never more than one cycle per accept.
- clear=1 at an edge (RST=0), from any state:
  - state <= FILL, index <= 0.
  - loaded <= 0, loadDone <= 0, selects <= 0.
  - data0..data5 retain their current values; only RST restores RESET_VALUE.
- clear and dataValid in the same cycle: dataReady is 0, the word is not accepted and no slot is written. The source must re-present it.
- clear in the same cycle as the sixth accept: clear wins. No write, no loadDone, index -> 0.
- Back-to-back accepts (dataValid held high): one word per cycle. Six words take exactly 6 consecutive cycles, and loadDone follows the sixth edge.
- dataValid toggling with gaps: the index advances only on accepted cycles. Gaps produce no strobes.
- RST mid-fill: partial contents are discarded (all slots to RESET_VALUE) and the sequence restarts at slot 0.
- Index never exceeds 5. Any illegal state/index encoding recovers to FILL with index 0 on the next edge.

Test Plan:
- Reset check: hold RST 2 cycles, release.
  - -> data0..5 = 32'hfefefefe, selects 0, loaded 0, loadDone 0.
  - -> dataReady 1 in the first cycle after release.
- Burst fill: dataValid=1 for 6 cycles with words 32'h01234567, 89abcdef, fedcba98, 76543210, 00000000, ffffffff.
  - -> select0..select5 pulse in successive cycles.
  - -> data0..5 equal those words.
  - -> loaded=1 and loadDone=1 in the cycle select5 is high; dataReady=0 afterwards.
- Gapped fill: valid on cycles 0,3,4,9,10,15.
  - -> strobes only one cycle after those accepts.
  - -> final contents are identical to the burst case; loadDone fires once.
- Overflow: after FULL, drive dataValid=1 with 32'hdeadbeef for 5 cycles.
  - -> dataReady=0, no selects, all slots unchanged, loaded stays 1.
- Clear mid-fill: after 3 accepts, assert clear for 1 cycle with dataValid=1 and word 32'haaaaaaaa.
  - -> word not written, loaded 0, data0..2 retain old values.
  - -> the next accepted word 32'h11111111 goes to data0 with select0.
- Clear on sixth word / reset mid-fill:
  - clear together with the sixth valid -> no loadDone, data5 unchanged, index 0.
  - Separately, RST after 4 accepts -> all slots 32'hfefefefe, refill starts at data0.
